// File: rtl/sw_debouncer_if.sv
// Switch conditioning bundle: raw switch levels in, debounced level and edge pulses out.
// Latency: none (wiring only).
// Backpressure: none; all signals are level/pulse, no handshake.
interface sw_debouncer_if #(
  parameter int NB_SW = 4
);
  logic [NB_SW-1:0] i_sw;
  logic [NB_SW-1:0] o_sw;
  logic [NB_SW-1:0] o_sw_rise;
  logic [NB_SW-1:0] o_sw_fall;

  // Board/switch side drives raw levels and consumes the conditioned view.
  modport master (
    output i_sw,
    input  o_sw,
    input  o_sw_rise,
    input  o_sw_fall
  );

  // Debouncer side.
  modport slave (
    input  i_sw,
    output o_sw,
    output o_sw_rise,
    output o_sw_fall
  );
endinterface

// File: rtl/sw_debouncer.sv
// Per-bit switch conditioner: 2-FF synchronizer followed by a counter debounce filter.
// Latency: a level captured into sync1 at edge k reaches o_sw at edge k+DEB_LIMIT+1.
// Backpressure: none; free-running, all outputs registered, no path from i_sw to outputs.
module sw_debouncer #(
  parameter int NB_SW     = 4,
  parameter int NB_DEB    = 14,
  parameter int DEB_LIMIT = 10000  // 2 <= DEB_LIMIT < 2**NB_DEB
) (
  input  logic          clock,
  input  logic          i_reset,
  sw_debouncer_if.slave sw
);

  localparam logic [NB_DEB-1:0] CNT_LAST = NB_DEB'(DEB_LIMIT - 1);
  localparam logic [NB_DEB-1:0] CNT_ONE  = NB_DEB'(1);

  logic [NB_SW-1:0]             sync1_q, sync1_d;
  logic [NB_SW-1:0]             sync2_q, sync2_d;
  logic [NB_SW-1:0]             sw_q,    sw_d;
  logic [NB_SW-1:0]             rise_q,  rise_d;
  logic [NB_SW-1:0]             fall_q,  fall_d;
  logic [NB_SW-1:0][NB_DEB-1:0] cnt_q,   cnt_d;

  // Synchronizer shift; only the second stage is allowed to reach the filter.
  always_comb begin
    sync1_d = sw.i_sw;
    sync2_d = sync1_q;
  end

  // Per-bit filter. The bit is PENDING whenever sync2 disagrees with the accepted
  // level; the count only advances while it disagrees, so any return to agreement
  // before the last count discards the glitch. Clearing at CNT_LAST keeps the
  // counter from ever wrapping.
  always_comb begin
    sw_d   = sw_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    for (int b = 0; b < NB_SW; b++) begin
      if (sync2_q[b] == sw_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_LAST) begin
        cnt_d[b]  = '0;
        sw_d[b]   = sync2_q[b];
        rise_d[b] = sync2_q[b];
        fall_d[b] = ~sync2_q[b];
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_ONE;
      end
    end
  end

  // State registers with synchronous reset; reset also drops any count in progress.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sw_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw.o_sw      = sw_q;
  assign sw.o_sw_rise = rise_q;
  assign sw.o_sw_fall = fall_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// Bench for sw_debouncer: scoreboard of expected level changes, checked every cycle.
// Latency: stimulus driven on a falling edge is expected on o_sw DEB_LIMIT+2 edges later.
// Backpressure: none; outputs sampled on the falling edge.
module tb_sw_debouncer;
  localparam int NB_SW     = 4;
  localparam int NB_DEB    = 14;
  localparam int DEB_LIMIT = 4;
  // Driven at a falling edge: captured at the next rising edge k, accepted at k+DEB_LIMIT+1.
  localparam int LAT = DEB_LIMIT + 2;

  typedef struct {
    int         due;
    logic [3:0] sw;
    logic [3:0] rise;
    logic [3:0] fall;
  } ev_t;

  logic       clock = 1'b0;
  logic       i_reset;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  ev_t        sbq[$];
  logic [3:0] exp_sw = 4'h0;
  logic [3:0] sb_level = 4'h0;
  logic [3:0] es, er, ef;

  sw_debouncer_if #(.NB_SW(NB_SW)) sw_if ();

  sw_debouncer #(
    .NB_SW    (NB_SW),
    .NB_DEB   (NB_DEB),
    .DEB_LIMIT(DEB_LIMIT)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .sw     (sw_if)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Record an accepted level change that the filter must produce LAT edges from now.
  task automatic expect_change(input logic [3:0] new_level);
    ev_t ev;
    ev.due    = cyc + LAT;
    ev.sw     = new_level;
    ev.rise   = new_level & ~sb_level;
    ev.fall   = ~new_level & sb_level;
    sb_level  = new_level;
    sbq.push_back(ev);
  endtask

  // Move to the next falling edge and work out what the outputs should be there.
  task automatic advance();
    ev_t ev;
    @(negedge clock);
    if (sbq.size() != 0 && sbq[0].due == cyc) begin
      ev     = sbq.pop_front();
      exp_sw = ev.sw;
      er     = ev.rise;
      ef     = ev.fall;
    end else begin
      er = 4'h0;
      ef = 4'h0;
    end
    es = exp_sw;
  endtask

  task automatic test_reset();
    i_reset    = 1'b1;
    sw_if.i_sw = 4'h0;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) sw_if.i_sw = (i % 2 == 1) ? 4'hF : 4'h0;
      if (i == 10) begin
        i_reset    = 1'b0;
        sw_if.i_sw = 4'h0;
      end
      advance();
      checks++;
      if ({sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall} !== {es, er, ef}) begin
        failures++;
        $display("FAIL reset cyc=%0d got sw=%h rise=%h fall=%h want sw=%h rise=%h fall=%h",
                 cyc, sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall, es, er, ef);
      end
    end
  endtask

  task automatic test_clean_step();
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        sw_if.i_sw[0] = 1'b1;
        expect_change(4'h1);
      end
      if (i == 10) begin
        sw_if.i_sw[0] = 1'b0;
        expect_change(4'h0);
      end
      advance();
      checks++;
      if ({sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall} !== {es, er, ef}) begin
        failures++;
        $display("FAIL clean_step cyc=%0d got sw=%h rise=%h fall=%h want sw=%h rise=%h fall=%h",
                 cyc, sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall, es, er, ef);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL clean_step_drain pending=%0d want 0", sbq.size());
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 12; i++) begin
      if (i == 0) sw_if.i_sw[1] = 1'b1;
      if (i == 3) sw_if.i_sw[1] = 1'b0;
      advance();
      checks++;
      if ({sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall} !== {es, er, ef}) begin
        failures++;
        $display("FAIL glitch cyc=%0d got sw=%h rise=%h fall=%h want sw=%h rise=%h fall=%h",
                 cyc, sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall, es, er, ef);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 34; i++) begin
      if (i < 12) sw_if.i_sw[2] = ((i / 2) % 2 == 0);
      if (i == 12) begin
        sw_if.i_sw[2] = 1'b1;
        expect_change(4'h4);
      end
      if (i == 24) begin
        sw_if.i_sw[2] = 1'b0;
        expect_change(4'h0);
      end
      advance();
      checks++;
      if ({sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall} !== {es, er, ef}) begin
        failures++;
        $display("FAIL bounce cyc=%0d got sw=%h rise=%h fall=%h want sw=%h rise=%h fall=%h",
                 cyc, sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall, es, er, ef);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL bounce_drain pending=%0d want 0", sbq.size());
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 30; i++) begin
      if (i == 0) begin
        sw_if.i_sw = 4'hA;
        expect_change(4'hA);
      end
      if (i == 10) begin
        sw_if.i_sw = 4'h5;
        expect_change(4'h5);
      end
      if (i == 20) begin
        sw_if.i_sw = 4'h0;
        expect_change(4'h0);
      end
      advance();
      checks++;
      if ({sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall} !== {es, er, ef}) begin
        failures++;
        $display("FAIL simultaneous cyc=%0d got sw=%h rise=%h fall=%h want sw=%h rise=%h fall=%h",
                 cyc, sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall, es, er, ef);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL simultaneous_drain pending=%0d want 0", sbq.size());
    end
  endtask

  // Reset lands when bit 0 has counted to 2; the debounce must restart from scratch.
  task automatic test_reset_mid_pending();
    for (int i = 0; i < 20; i++) begin
      if (i == 0) sw_if.i_sw[0] = 1'b1;
      if (i == 4) i_reset = 1'b1;
      if (i == 8) begin
        i_reset = 1'b0;
        expect_change(4'h1);
      end
      advance();
      checks++;
      if ({sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall} !== {es, er, ef}) begin
        failures++;
        $display("FAIL reset_mid_pending cyc=%0d got sw=%h rise=%h fall=%h want sw=%h rise=%h fall=%h",
                 cyc, sw_if.o_sw, sw_if.o_sw_rise, sw_if.o_sw_fall, es, er, ef);
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_pending_drain pending=%0d want 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
